// File: rtl/imm_inst_encoder.sv
// RV32I OP-IMM (I-type ALU) instruction encoder feeding a 2-entry output FIFO,
// with a start/run/done controller that bounds each run to MAX_WORDS words.

package imm_inst_encoder_pkg;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_ADDI  = 5'd1;
  localparam logic [4:0] ALU_SLTI  = 5'd2;
  localparam logic [4:0] ALU_SLTIU = 5'd3;
  localparam logic [4:0] ALU_XORI  = 5'd4;
  localparam logic [4:0] ALU_ORI   = 5'd5;
  localparam logic [4:0] ALU_ANDI  = 5'd6;
  localparam logic [4:0] ALU_SLLI  = 5'd7;
  localparam logic [4:0] ALU_SRLI  = 5'd8;
  localparam logic [4:0] ALU_SRAI  = 5'd9;

  localparam logic [6:0]  OPCODE_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        illegal;
  } fifo_entry_t;

endpackage

module imm_inst_encoder
  import imm_inst_encoder_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  alu_control,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rd,
  input  logic [11:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] addr,
  output logic        illegal,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_count
);

  localparam logic [9:0] MAX_CNT = 10'(MAX_WORDS);

  state_t      state_q;
  fifo_entry_t slot_q [2];
  logic [1:0]  count_q, count_d;
  logic [9:0]  accepted_q, accepted_d;
  logic [31:0] addr_q;
  logic [7:0]  err_q;
  logic        busy_q, done_q;

  logic        push, pop, wr_idx;
  logic [31:0] enc_word;
  logic        enc_illegal;
  fifo_entry_t new_entry;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    enc_word    = NOP_WORD;
    enc_illegal = 1'b0;
    case (alu_control)
      ALU_ADDI:  enc_word = {imm, rs1, 3'd0, rd, OPCODE_OP_IMM};
      ALU_SLTI:  enc_word = {imm, rs1, 3'd2, rd, OPCODE_OP_IMM};
      ALU_SLTIU: enc_word = {imm, rs1, 3'd3, rd, OPCODE_OP_IMM};
      ALU_XORI:  enc_word = {imm, rs1, 3'd4, rd, OPCODE_OP_IMM};
      ALU_ORI:   enc_word = {imm, rs1, 3'd6, rd, OPCODE_OP_IMM};
      ALU_ANDI:  enc_word = {imm, rs1, 3'd7, rd, OPCODE_OP_IMM};
      ALU_SLLI:  enc_word = {7'h00, imm[4:0], rs1, 3'd1, rd, OPCODE_OP_IMM};
      ALU_SRLI:  enc_word = {7'h00, imm[4:0], rs1, 3'd5, rd, OPCODE_OP_IMM};
      ALU_SRAI:  enc_word = {7'h20, imm[4:0], rs1, 3'd5, rd, OPCODE_OP_IMM};
      default:   enc_illegal = 1'b1;
    endcase
  end

  assign new_entry = '{instr: enc_word, addr: addr_q, illegal: enc_illegal};

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q == ST_RUN) && (count_q < 2'd2) && (accepted_q < MAX_CNT);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign count_d    = count_q + {1'b0, push} - {1'b0, pop};
  assign accepted_d = accepted_q + {9'd0, push};
  // Slot 0 is always the head; an incoming word lands there if the head is leaving.
  assign wr_idx     = (count_q == 2'd0 || pop) ? 1'b0 : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= 2'd0;
      accepted_q <= 10'd0;
      addr_q     <= BASE_ADDR;
      err_q      <= 8'd0;
      // NOTE: the FIFO slots are reset as well, so instr/addr/illegal read zero after reset.
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      count_q <= count_d;
      if (pop) begin
        slot_q[0] <= slot_q[1];
      end
      if (push) begin
        slot_q[wr_idx] <= new_entry;
        addr_q         <= addr_q + 32'd4;
        accepted_q     <= accepted_d;
        if (enc_illegal && err_q != 8'hFF) begin
          err_q <= err_q + 8'd1;
        end
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            accepted_q <= 10'd0;
            err_q      <= 8'd0;
            addr_q     <= BASE_ADDR;
          end
        end
        ST_RUN: begin
          if (accepted_d == MAX_CNT && count_d == 2'd0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instr     = slot_q[0].instr;
  assign addr      = slot_q[0].addr;
  assign illegal   = slot_q[0].illegal;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Self-checking bench for imm_inst_encoder: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.

module tb_imm_inst_encoder;
  import imm_inst_encoder_pkg::*;

  localparam int          MAXW = 12;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [4:0]  alu_control, rs1, rd;
  logic [11:0] imm;
  logic        in_ready, out_valid, illegal, busy, done;
  logic [31:0] instr, addr;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  imm_inst_encoder #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .rs1(rs1), .rd(rd), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .addr(addr), .illegal(illegal),
    .busy(busy), .done(done), .err_count(err_count)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [11:0] imm;
  } stim_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        ill;
  } ent_t;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  ent_t        m_q[$];
  int          m_state;   // 0 idle, 1 run, 2 done
  int          m_acc;
  int          m_err;
  logic [31:0] m_addr;

  stim_t       pend[$];
  ent_t        lit_q[$];
  bit          use_pend;
  bit          seq_on;
  logic [31:0] seq_addr;
  int          n_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input stim_t s, output bit ill);
    int          f3;
    logic [31:0] hi;
    ill = 1'b0;
    f3  = 0;
    hi  = 32'(s.imm);
    case (s.op)
      ALU_ADDI:  f3 = 0;
      ALU_SLTI:  f3 = 2;
      ALU_SLTIU: f3 = 3;
      ALU_XORI:  f3 = 4;
      ALU_ORI:   f3 = 6;
      ALU_ANDI:  f3 = 7;
      ALU_SLLI:  begin f3 = 1; hi = 32'(s.imm[4:0]); end
      ALU_SRLI:  begin f3 = 5; hi = 32'(s.imm[4:0]); end
      ALU_SRAI:  begin f3 = 5; hi = 32'h400 + 32'(s.imm[4:0]); end
      default:   ill = 1'b1;
    endcase
    if (ill) return 32'h0000_0013;
    return (hi << 20) | (32'(s.rs1) << 15) | (32'(f3) << 12) | (32'(s.rd) << 7) | 32'h13;
  endfunction

  function automatic bit model_ready();
    return (m_state == 1) && (m_q.size() < 2) && (m_acc < MAXW);
  endfunction

  task automatic compare_outputs();
    check("in_ready", 32'(in_ready), 32'(model_ready()));
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("instr", instr, m_q[0].instr);
      check("addr", addr, m_q[0].addr);
      check("illegal", 32'(illegal), 32'(m_q[0].ill));
    end
    check("busy", 32'(busy), 32'(m_state == 1));
    check("done", 32'(done), 32'(m_state == 2));
    check("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic tick();
    bit          mrdy, acc, pop, ill;
    logic [31:0] w;
    stim_t       s;
    ent_t        e;
    if (out_valid === 1'b1 && out_ready) begin
      n_valid++;
      if (lit_q.size() > 0) begin
        e = lit_q.pop_front();
        check("lit_instr", instr, e.instr);
        check("lit_addr", addr, e.addr);
        check("lit_illegal", 32'(illegal), 32'(e.ill));
      end
      if (seq_on) begin
        check("seq_addr", addr, seq_addr);
        seq_addr += 32'd4;
      end
    end else if (out_valid === 1'b1) begin
      n_valid++;
    end
    mrdy = model_ready();
    acc  = in_valid && mrdy;
    pop  = (m_q.size() > 0) && out_ready;
    s    = '{alu_control, rs1, rd, imm};
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_state = 0; m_acc = 0; m_err = 0; m_addr = BASE;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        w = ref_encode(s, ill);
        m_q.push_back('{w, m_addr, ill});
        m_addr += 32'd4;
        m_acc++;
        if (ill && m_err < 255) m_err++;
        if (use_pend && pend.size() > 0) void'(pend.pop_front());
      end
      if (m_state != 1 && start) begin
        m_state = 1; m_acc = 0; m_err = 0; m_addr = BASE;
      end else if (m_state == 1 && m_acc == MAXW && m_q.size() == 0) begin
        m_state = 2;
      end
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic drive_pending();
    if (pend.size() > 0) begin
      in_valid    = 1'b1;
      alu_control = pend[0].op;
      rs1         = pend[0].rs1;
      rd          = pend[0].rd;
      imm         = pend[0].imm;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic fill_pend(input int n, input bit allow_ill);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s.op  = allow_ill ? 5'($urandom_range(0, 12)) : 5'($urandom_range(1, 9));
      s.rs1 = 5'($urandom);
      s.rd  = 5'($urandom);
      s.imm = 12'($urandom);
      pend.push_back(s);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    drive_pending();
    check("start_cycle_in_ready", 32'(in_ready), 32'd0);
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string name);
    n_valid = 0;
    for (int i = 0; i < budget && done !== 1'b1; i++) begin
      drive_pending();
      tick();
    end
    check(name, 32'(done), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; rs1 = '0; rd = '0; imm = '0;
    use_pend = 1'b1; seq_on = 1'b0; seq_addr = BASE; n_valid = 0;
    m_state = 0; m_acc = 0; m_err = 0; m_addr = BASE;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Basic encodes with literal expectations, streaming one word per cycle
    out_ready = 1'b1;
    pend.push_back('{ALU_ADDI, 5'd2, 5'd1, 12'd5});
    pend.push_back('{ALU_XORI, 5'd6, 5'd5, 12'hFFF});
    pend.push_back('{ALU_SRAI, 5'd4, 5'd3, 12'd7});
    pend.push_back('{ALU_SLLI, 5'd1, 5'd1, 12'hFFF});
    fill_pend(MAXW - 4, 1'b0);
    lit_q.push_back('{32'h0051_0093, 32'd0,  1'b0});
    lit_q.push_back('{32'hFFF3_4293, 32'd4,  1'b0});
    lit_q.push_back('{32'h4072_5193, 32'd8,  1'b0});
    lit_q.push_back('{32'h01F0_9093, 32'd12, 1'b0});
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    run_until_done(100, "basic_done");
    check("basic_stream_cycles", 32'(n_valid), 32'(MAXW));
    check("basic_lit_consumed", 32'(lit_q.size()), 32'd0);
    tick();
    tick();
    check("done_in_ready_low", 32'(in_ready), 32'd0);
    check("done_held", 32'(done), 32'd1);

    // Illegal operation followed by a legal word
    pend.push_back('{ALU_NOP, 5'd7, 5'd9, 12'h123});
    pend.push_back('{ALU_ADDI, 5'd2, 5'd1, 12'd5});
    fill_pend(MAXW - 2, 1'b0);
    lit_q.push_back('{32'h0000_0013, 32'd0, 1'b1});
    lit_q.push_back('{32'h0051_0093, 32'd4, 1'b0});
    pulse_start();
    run_until_done(100, "illegal_done");
    check("illegal_err_count", 32'(err_count), 32'd1);

    // Backpressure: only two words enter while the consumer stalls
    out_ready = 1'b0;
    fill_pend(MAXW, 1'b1);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      drive_pending();
      tick();
    end
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head_addr", addr, 32'd0);
    check("bp_pending_left", 32'(pend.size()), 32'(MAXW - 2));
    out_ready = 1'b1;
    seq_on = 1'b1; seq_addr = BASE;
    run_until_done(200, "bp_done");
    check("bp_word_total", seq_addr, 32'(4 * MAXW));
    seq_on = 1'b0;

    // Start pulsed during RUN is ignored
    fill_pend(MAXW, 1'b1);
    seq_on = 1'b1; seq_addr = BASE;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      drive_pending();
      tick();
    end
    start = 1'b1;
    drive_pending();
    tick();
    start = 1'b0;
    run_until_done(200, "restart_ignored_done");
    check("restart_word_total", seq_addr, 32'(4 * MAXW));
    seq_on = 1'b0;

    // Reset mid-run after two accepts
    out_ready = 1'b0;
    pend.push_back('{ALU_NOP, 5'd1, 5'd1, 12'd0});
    fill_pend(4, 1'b1);
    pulse_start();
    for (int i = 0; i < 10 && m_acc < 2; i++) begin
      drive_pending();
      tick();
    end
    check("mid_accepts", 32'(m_acc), 32'd2);
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    pend.delete();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_addr", addr, 32'd0);
    check("mid_rst_illegal", 32'(illegal), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    fill_pend(MAXW, 1'b0);
    seq_on = 1'b1; seq_addr = BASE;
    pulse_start();
    check("restart_err_zero", 32'(err_count), 32'd0);
    run_until_done(200, "post_reset_done");
    seq_on = 1'b0;

    // Randomized traffic, including stray starts and occasional resets
    use_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 399) == 0);
      start       = ($urandom_range(0, 14) == 0);
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      alu_control = 5'($urandom_range(0, 12));
      rs1         = 5'($urandom);
      rd          = 5'($urandom);
      imm         = 12'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
